uart_txrx: RTL and testbench

- Full-duplex 8-bit UART: one transmitter and one receiver, sharing one clock and parameter set.
- Optional even parity on both directions.
- Top-level serial block between a byte-level client and the txd/rxd pins.
- Loopback use (txd wired to rxd) is a supported configuration.

---
 rtl/uart_txrx_if.sv | 28 ++
 rtl/uart_txrx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_txrx.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_txrx_if.sv
// Byte-level client interface of the UART.
//   master : client side (drives tx_en/tx_dfifo, observes status and received byte)
//   slave  : UART side
// Signals:
//   tx_en         transmit request, level-sensitive
//   tx_dfifo      byte to transmit
//   tx_busy       transmitter is inside a frame
//   rx_dfifo      last received byte
//   rx_busy       receiver is inside a frame
//   rx_parity_err parity mismatch on the last received frame
interface uart_txrx_if;
    logic       tx_en;
    logic [7:0] tx_dfifo;
    logic       tx_busy;
    logic [7:0] rx_dfifo;
    logic       rx_busy;
    logic       rx_parity_err;

    modport master (
        output tx_en, tx_dfifo,
        input  tx_busy, rx_dfifo, rx_busy, rx_parity_err
    );

    modport slave (
        input  tx_en, tx_dfifo,
        output tx_busy, rx_dfifo, rx_busy, rx_parity_err
    );
endinterface

// File: rtl/uart_txrx.sv
// Full-duplex 8-bit UART, optional even parity (start, D0..D7 LSB first, [parity], stop).
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset, aborts any frame in progress
//   cif   byte-level client interface (slave modport)
//   rxd   serial input, idle high, asynchronous to clk
//   txd   serial output, idle high
//
// TX states:
//   state     | meaning
//   TX_IDLE   | line high, waiting for tx_en
//   TX_START  | driving start bit (0)
//   TX_DATA   | driving D0..D7, tx_bit selects the bit
//   TX_PARITY | driving even parity bit (PARITY_EN only)
//   TX_STOP   | driving stop bit (1)
// RX states:
//   state     | meaning
//   RX_IDLE   | waiting for a synchronized falling edge
//   RX_START  | waiting half a bit to re-check the start bit
//   RX_DATA   | sampling D0..D7 at bit centres, rxd_cnt = bit index
//   RX_PARITY | sampling the parity bit (PARITY_EN only)
//   RX_STOP   | stop-bit centre: deliver byte and parity status
module uart_txrx #(
    parameter int CLK_FREQ  = 10_000_000,
    parameter int BAUDRATE  = 9600,
    parameter int PARITY_EN = 0
) (
    input  logic       clk,
    input  logic       rstn,
    uart_txrx_if.slave cif,
    input  logic       rxd,
    output logic       txd
);
    localparam int BIT_CYC  = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CYC - 1);
    localparam bit PAR = (PARITY_EN != 0);

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shreg, tx_shreg_nxt;
    logic          txd_nxt;
    logic          tx_tc;

    assign tx_tc       = (tx_cnt == '0);
    assign cif.tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shreg <= tx_shreg_nxt;
            txd      <= txd_nxt;
        end
    end

    // txd is registered: the value for the next bit is chosen on the edge that enters it.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_tc ? tx_cnt : tx_cnt - 1'b1;
        tx_bit_nxt   = tx_bit;
        tx_shreg_nxt = tx_shreg;
        txd_nxt      = txd;
        unique case (tx_state)
            TX_IDLE: begin
                txd_nxt = 1'b1;
                if (cif.tx_en) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = BIT_LOAD;
                    tx_shreg_nxt = cif.tx_dfifo;
                    txd_nxt      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_tc) begin
                    tx_state_nxt = TX_DATA;
                    tx_cnt_nxt   = BIT_LOAD;
                    tx_bit_nxt   = '0;
                    txd_nxt      = tx_shreg[0];
                end
            end
            TX_DATA: begin
                if (tx_tc) begin
                    tx_cnt_nxt = BIT_LOAD;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = PAR ? TX_PARITY : TX_STOP;
                        txd_nxt      = PAR ? ^tx_shreg : 1'b1;
                    end else begin
                        tx_bit_nxt = tx_bit + 3'd1;
                        txd_nxt    = tx_shreg[tx_bit + 3'd1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tc) begin
                    tx_state_nxt = TX_STOP;
                    tx_cnt_nxt   = BIT_LOAD;
                    txd_nxt      = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tc) begin
                    tx_state_nxt = TX_IDLE;
                    txd_nxt      = 1'b1;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                txd_nxt      = 1'b1;
            end
        endcase
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rxd_cnt, rxd_cnt_nxt;
    logic [7:0]    rx_shreg, rx_shreg_nxt;
    logic [7:0]    rx_dfifo_q, rx_dfifo_nxt;
    logic          rx_par_bit, rx_par_bit_nxt;
    logic          rx_perr_q, rx_perr_nxt;
    logic          rxd_s1, rxd_s2, rxd_s3;
    logic          rx_fall, rx_tc;

    // Synchronizer flops reset high so reset release never looks like a start edge.
    assign rx_fall           = rxd_s3 & ~rxd_s2;
    assign rx_tc             = (rx_cnt == '0);
    assign cif.rx_busy       = (rx_state != RX_IDLE);
    assign cif.rx_dfifo      = rx_dfifo_q;
    assign cif.rx_parity_err = rx_perr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_s1     <= 1'b1;
            rxd_s2     <= 1'b1;
            rxd_s3     <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rxd_cnt    <= '0;
            rx_shreg   <= '0;
            rx_dfifo_q <= '0;
            rx_par_bit <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rxd_s1     <= rxd;
            rxd_s2     <= rxd_s1;
            rxd_s3     <= rxd_s2;
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rxd_cnt    <= rxd_cnt_nxt;
            rx_shreg   <= rx_shreg_nxt;
            rx_dfifo_q <= rx_dfifo_nxt;
            rx_par_bit <= rx_par_bit_nxt;
            rx_perr_q  <= rx_perr_nxt;
        end
    end

    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_tc ? rx_cnt : rx_cnt - 1'b1;
        rxd_cnt_nxt    = rxd_cnt;
        rx_shreg_nxt   = rx_shreg;
        rx_dfifo_nxt   = rx_dfifo_q;
        rx_par_bit_nxt = rx_par_bit;
        rx_perr_nxt    = rx_perr_q;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = HALF_LOAD;
                    rx_perr_nxt  = 1'b0;
                end
            end
            RX_START: begin
                if (rx_tc) begin
                    if (rxd_s2) begin
                        rx_state_nxt = RX_IDLE;     // glitch, not a real start bit
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_cnt_nxt   = BIT_LOAD;
                        rxd_cnt_nxt  = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tc) begin
                    rx_cnt_nxt   = BIT_LOAD;
                    rx_shreg_nxt = {rxd_s2, rx_shreg[7:1]};
                    if (rxd_cnt == 3'd7) begin
                        rx_state_nxt = PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rxd_cnt_nxt = rxd_cnt + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tc) begin
                    rx_state_nxt   = RX_STOP;
                    rx_cnt_nxt     = BIT_LOAD;
                    rx_par_bit_nxt = rxd_s2;
                end
            end
            RX_STOP: begin
                // Stop-bit level is not checked; the byte is delivered regardless.
                if (rx_tc) begin
                    rx_state_nxt = RX_IDLE;
                    rx_dfifo_nxt = rx_shreg;
                    rx_perr_nxt  = PAR && (rx_par_bit != ^rx_shreg);
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_txrx.sv
module tb_uart_txrx;
    localparam int NI        = 3;
    localparam int FAST_CLK  = 1_000_000;
    localparam int FAST_BAUD = 62_500;

    // instance 0: 10 MHz / 9600 8N1, instance 1: fast 8N1, instance 2: fast 8E1
    int bit_cyc [NI] = '{1042, 16, 16};
    bit par_en  [NI] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rstn;
    int         cyc = 0;
    logic       tx_en    [NI];
    logic [7:0] tx_dfifo [NI];
    logic       force_hi [NI];
    logic       force_lo [NI];
    logic       txd      [NI];
    logic       rxd      [NI];
    logic       tx_busy  [NI];
    logic       rx_busy  [NI];
    logic       perr     [NI];
    logic [7:0] rx_dfifo [NI];

    uart_txrx_if if0 ();
    uart_txrx_if if1 ();
    uart_txrx_if if2 ();

    assign if0.tx_en = tx_en[0];  assign if0.tx_dfifo = tx_dfifo[0];
    assign if1.tx_en = tx_en[1];  assign if1.tx_dfifo = tx_dfifo[1];
    assign if2.tx_en = tx_en[2];  assign if2.tx_dfifo = tx_dfifo[2];
    assign tx_busy[0] = if0.tx_busy;  assign rx_busy[0] = if0.rx_busy;
    assign rx_dfifo[0] = if0.rx_dfifo; assign perr[0] = if0.rx_parity_err;
    assign tx_busy[1] = if1.tx_busy;  assign rx_busy[1] = if1.rx_busy;
    assign rx_dfifo[1] = if1.rx_dfifo; assign perr[1] = if1.rx_parity_err;
    assign tx_busy[2] = if2.tx_busy;  assign rx_busy[2] = if2.rx_busy;
    assign rx_dfifo[2] = if2.rx_dfifo; assign perr[2] = if2.rx_parity_err;

    for (genvar g = 0; g < NI; g++) begin : g_loop
        assign rxd[g] = (txd[g] | force_hi[g]) & ~force_lo[g];
    end

    uart_txrx u_def (.clk(clk), .rstn(rstn), .cif(if0), .rxd(rxd[0]), .txd(txd[0]));
    uart_txrx #(.CLK_FREQ(FAST_CLK), .BAUDRATE(FAST_BAUD), .PARITY_EN(0))
        u_np (.clk(clk), .rstn(rstn), .cif(if1), .rxd(rxd[1]), .txd(txd[1]));
    uart_txrx #(.CLK_FREQ(FAST_CLK), .BAUDRATE(FAST_BAUD), .PARITY_EN(1))
        u_par (.clk(clk), .rstn(rstn), .cif(if2), .rxd(rxd[2]), .txd(txd[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        bit         chk_perr;
    } exp_t;

    exp_t       sb_q [NI][$];
    exp_t       mon_e;
    logic [7:0] last_data [NI];
    logic       prev_busy [NI];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Monitor: every end of an rx_busy window is one delivered result.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rstn && prev_busy[i] && !rx_busy[i]) begin
                if (sb_q[i].size() == 0) begin
                    check($sformatf("rx%0d_unexpected_frame", i), 32'(rx_dfifo[i]), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb_q[i].pop_front();
                    check($sformatf("rx%0d_data", i), 32'(rx_dfifo[i]), 32'(mon_e.data));
                    if (mon_e.chk_perr)
                        check($sformatf("rx%0d_parity_err", i), 32'(perr[i]), 32'(mon_e.perr));
                end
            end
            prev_busy[i] = rstn ? rx_busy[i] : 1'b0;
        end
    end

    // Loopback one byte on instance i; inj forces the line high during D7.
    task automatic send(input int i, input logic [7:0] b, input bit inj);
        int   t0, bc, fb, w0, w1, w2;
        logic fbits [11];
        exp_t e;
        bc = bit_cyc[i];
        fb = par_en[i] ? 11 : 10;
        fbits[0] = 1'b0;
        for (int k = 0; k < 8; k++) fbits[k+1] = b[k];
        fbits[9]  = par_en[i] ? ^b : 1'b1;
        fbits[10] = 1'b1;
        e.data     = inj ? (b | 8'h80) : b;
        e.perr     = par_en[i] && ((^e.data) != (^b));
        e.chk_perr = 1'b1;
        sb_q[i].push_back(e);
        last_data[i] = e.data;

        @(negedge clk);
        tx_dfifo[i] = b;
        tx_en[i]    = 1'b1;
        w0 = 0;
        while (txd[i] !== 1'b0 && w0 < 20) begin @(negedge clk); w0++; end
        check($sformatf("tx%0d_start_latency", i), 32'(w0), 32'd1);
        check($sformatf("tx%0d_busy_at_start", i), 32'(tx_busy[i]), 32'd1);
        t0 = cyc;
        tx_dfifo[i] = ~b;
        fork
            begin
                for (int k = 0; k < fb; k++) begin
                    while (cyc < t0 + k * bc + bc / 2) @(negedge clk);
                    check($sformatf("tx%0d_frame_bit%0d", i, k), 32'(txd[i]), 32'(fbits[k]));
                end
            end
            begin
                if (inj) begin
                    while (cyc < t0 + 8 * bc) @(negedge clk);
                    force_hi[i] = 1'b1;
                    while (cyc < t0 + 9 * bc) @(negedge clk);
                    force_hi[i] = 1'b0;
                end
            end
            begin
                w1 = 0;
                while (!rx_busy[i] && w1 < 10) begin @(negedge clk); w1++; end
                check($sformatf("rx%0d_busy_rise_lat", i), 32'(cyc - t0), 32'd3);
                check($sformatf("rx%0d_perr_clear_at_start", i), 32'(perr[i]), 32'd0);
                tx_en[i] = 1'b0;
                while (rx_busy[i] && (cyc - t0) < fb * bc + 20) @(negedge clk);
                check($sformatf("rx%0d_busy_fall_lat", i), 32'(cyc - t0), 32'(3 + bc / 2 + (fb - 1) * bc));
                check($sformatf("tx%0d_busy_at_rx_done", i), 32'(tx_busy[i]), 32'd1);
            end
        join
        w2 = 0;
        while (tx_busy[i] && (cyc - t0) < fb * bc + 20) @(negedge clk);
        check($sformatf("tx%0d_busy_fall_lat", i), 32'(cyc - t0), 32'(fb * bc));
        check($sformatf("tx%0d_idle_line", i), 32'(txd[i]), 32'd1);
    endtask

    task automatic glitch(input int i);
        exp_t e;
        bit   seen;
        e.data     = last_data[i];
        e.perr     = 1'b0;
        e.chk_perr = 1'b0;
        sb_q[i].push_back(e);
        seen = 1'b0;
        @(negedge clk);
        force_lo[i] = 1'b1;
        for (int k = 0; k < 2 * bit_cyc[i]; k++) begin
            @(negedge clk);
            if (k == bit_cyc[i] / 4 - 1) force_lo[i] = 1'b0;
            if (rx_busy[i]) seen = 1'b1;
        end
        check($sformatf("rx%0d_glitch_busy_pulse", i), 32'(seen), 32'd1);
        check($sformatf("rx%0d_glitch_busy_end", i), 32'(rx_busy[i]), 32'd0);
        check($sformatf("rx%0d_glitch_data_kept", i), 32'(rx_dfifo[i]), 32'(last_data[i]));
    endtask

    task automatic back_to_back(input int i);
        logic [7:0] a, b;
        exp_t       e;
        int         w, low;
        a = 8'($urandom);
        b = 8'($urandom);
        e.perr = 1'b0; e.chk_perr = 1'b1;
        e.data = a; sb_q[i].push_back(e);
        e.data = b; sb_q[i].push_back(e);
        last_data[i] = b;
        @(negedge clk);
        tx_dfifo[i] = a;
        tx_en[i]    = 1'b1;
        w = 0;
        while (txd[i] !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        tx_dfifo[i] = b;
        w = 0;
        while (tx_busy[i] && w < 12 * bit_cyc[i]) begin @(negedge clk); w++; end
        low = 0;
        while (!tx_busy[i] && low < 5) begin @(negedge clk); low++; end
        check("tx_b2b_idle_gap", 32'(low), 32'd1);
        tx_en[i] = 1'b0;
        w = 0;
        while ((tx_busy[i] || rx_busy[i]) && w < 12 * bit_cyc[i]) begin @(negedge clk); w++; end
        check("tx_b2b_second_done", 32'(tx_busy[i]), 32'd0);
    endtask

    task automatic reset_mid_tx(input int i);
        int t0, w;
        @(negedge clk);
        tx_dfifo[i] = 8'($urandom);
        tx_en[i]    = 1'b1;
        w = 0;
        while (txd[i] !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        t0 = cyc;
        tx_en[i] = 1'b0;
        while (cyc < t0 + 4 * bit_cyc[i] + bit_cyc[i] / 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_tx_txd", 32'(txd[i]), 32'd1);
        check("rst_mid_tx_busy", 32'(tx_busy[i]), 32'd0);
        check("rst_mid_tx_rx_busy", 32'(rx_busy[i]), 32'd0);
        check("rst_mid_tx_rx_dfifo", 32'(rx_dfifo[i]), 32'd0);
        for (int k = 0; k < NI; k++) last_data[k] = 8'h00;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send(i, 8'($urandom), 1'b0);
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            tx_en[i] = 1'b0; tx_dfifo[i] = 8'h00;
            force_hi[i] = 1'b0; force_lo[i] = 1'b0;
            last_data[i] = 8'h00; prev_busy[i] = 1'b0;
        end
        rstn = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset%0d_txd", i), 32'(txd[i]), 32'd1);
            check($sformatf("reset%0d_tx_busy", i), 32'(tx_busy[i]), 32'd0);
            check($sformatf("reset%0d_rx_busy", i), 32'(rx_busy[i]), 32'd0);
            check($sformatf("reset%0d_rx_dfifo", i), 32'(rx_dfifo[i]), 32'd0);
            check($sformatf("reset%0d_parity_err", i), 32'(perr[i]), 32'd0);
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        send(0, 8'h5C, 1'b0);
        send(0, 8'hDE, 1'b0);

        send(2, 8'hDE, 1'b0);
        send(2, 8'h5C, 1'b0);
        send(2, 8'h5C, 1'b1);
        send(2, 8'hDE, 1'b0);

        repeat (8) send(1, 8'($urandom), 1'b0);
        repeat (8) send(2, 8'($urandom), ($urandom_range(0, 3) == 0));

        glitch(1);
        glitch(2);
        back_to_back(1);
        reset_mid_tx(1);

        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("sb%0d_drained", i), 32'(sb_q[i].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
